// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one combinational 16-bit ALU. Each requester uses
// a valid/ready request handshake and a valid/ready response handshake. A
// round-robin grant accepts at most one operation per cycle. The accepted
// operands go into a registered issue stage that drives the ALU directly. The
// ALU result and status flags go into a one-entry response buffer for the
// requesting port. A saturating counter records how many requests have been
// accepted.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   req_valid    per-port request valid (bit i = port i)
//   req_ready    per-port grant (bit i = port i)
//   req_a        operand A, [WIDTH-1:0] = port 0, [2*WIDTH-1:WIDTH] = port 1
//   req_b        operand B, same packing as req_a
//   req_op       2-bit op per port: 00 ADD, 01 SUB, 10 OR, 11 AND
//   rsp_valid    per-port response valid
//   rsp_ready    per-port response consume
//   rsp_out      per-port result, same packing as req_a
//   rsp_stat     per-port {overflow, sign, zero}, [2:0] = port 0
//   alu_a        ALU operand A
//   alu_b        ALU operand B
//   alu_control  ALU operation select, same encoding as req_op
//   alu_out      ALU result, combinational from alu_a/alu_b/alu_control
//   alu_stat     ALU {overflow, sign, zero}
//   ops_issued   saturating count of accepted requests
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [3:0]           req_op,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_out,
    output logic [5:0]           rsp_stat,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [2:0]           alu_stat,
    output logic [CNT_W-1:0]     ops_issued
);

    logic             iss_valid;
    logic             iss_src;
    logic             rr_ptr;
    logic [1:0]       eligible;
    logic             grant_any;
    logic             grant_src;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_op;

    // Each port may have only one operation outstanding. While its operation
    // is in the issue register, or while its response buffer is full, the port
    // is not eligible. The grant is built only from registered state and
    // req_valid. The grant is held off during reset so that nothing is accepted
    // on the reset edge.
    always_comb begin
        eligible[0] = req_valid[0] && !(iss_valid && !iss_src) && !rsp_valid[0];
        eligible[1] = req_valid[1] && !(iss_valid &&  iss_src) && !rsp_valid[1];

        grant_any = 1'b0;
        grant_src = 1'b0;
        if (!rst) begin
            case (eligible)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_src = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_src = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_src = rr_ptr;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_src = 1'b0;
                end
            endcase
        end

        req_ready = 2'b00;
        if (grant_any) begin
            req_ready = grant_src ? 2'b10 : 2'b01;
        end

        sel_a  = grant_src ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        sel_b  = grant_src ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        sel_op = grant_src ? req_op[3:2]            : req_op[1:0];
    end

    // Issue stage. The ALU operand registers load only when an operation is
    // accepted. When the stage is empty, the ALU inputs keep their last values
    // and do not toggle. The round-robin pointer moves to the other port after
    // every grant and stays put in cycles with no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            iss_src     <= 1'b0;
            rr_ptr      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 2'b00;
        end else if (grant_any) begin
            iss_valid   <= 1'b1;
            iss_src     <= grant_src;
            rr_ptr      <= ~grant_src;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_control <= sel_op;
        end else begin
            iss_valid   <= 1'b0;
        end
    end

    // Response buffers. A consume clears the valid flag. The capture from the
    // issue stage never targets a port whose buffer is still full, because
    // such a port could not have been granted. So the capture and the consume
    // never compete for the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 2'b00;
            rsp_out   <= '0;
            rsp_stat  <= '0;
        end else begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                rsp_valid[0] <= 1'b0;
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                rsp_valid[1] <= 1'b0;
            end
            if (iss_valid) begin
                if (iss_src) begin
                    rsp_out[2*WIDTH-1:WIDTH] <= alu_out;
                    rsp_stat[5:3]            <= alu_stat;
                    rsp_valid[1]             <= 1'b1;
                end else begin
                    rsp_out[WIDTH-1:0]       <= alu_out;
                    rsp_stat[2:0]            <= alu_stat;
                    rsp_valid[0]             <= 1'b1;
                end
            end
        end
    end

    // Performance counter of accepted requests. It stops at all-ones instead
    // of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_issued <= '0;
        end else if (grant_any && (ops_issued != {CNT_W{1'b1}})) begin
            ops_issued <= ops_issued + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed testbench for alu_share_arbiter. A small reference ALU model is
// connected to the ALU ports. Each accepted request pushes its hand-computed
// result into a per-port queue. A monitor on the falling edge compares every
// presented response against the head of that queue. The ops_issued counter
// uses a narrow CNT_W so that saturation is reached within a few dozen
// accepts.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int W        = 16;
    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*W-1:0]      req_a;
    logic [2*W-1:0]      req_b;
    logic [3:0]          req_op;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*W-1:0]      rsp_out;
    logic [5:0]          rsp_stat;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [1:0]          alu_control;
    logic [W-1:0]        alu_out;
    logic [2:0]          alu_stat;
    logic [TB_CNT_W-1:0] ops_issued;

    logic [W-1:0]        alu_res;
    logic                alu_ovf;

    int                  compared   = 0;
    int                  mismatched = 0;
    logic [TB_CNT_W-1:0] exp_cnt;

    logic [W-1:0]        pa    [2];
    logic [W-1:0]        pb    [2];
    logic [1:0]          p_op  [2];
    logic [W-1:0]        pres  [2];
    logic [2:0]          pstat [2];

    logic [18:0]         expq0 [$];
    logic [18:0]         expq1 [$];

    logic [5:0]          t2 [6];
    logic [5:0]          t3 [14];
    logic [1:0]          t5 [3];

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .WIDTH (W),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_out     (rsp_out),
        .rsp_stat    (rsp_stat),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_stat    (alu_stat),
        .ops_issued  (ops_issued)
    );

    // Reference ALU: two's-complement ADD/SUB with signed overflow, and OR/AND
    // with overflow forced to 0.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_control)
            2'b00: begin
                alu_res = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            2'b01: begin
                alu_res = alu_a - alu_b;
                alu_ovf = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            2'b10:   alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    assign alu_out  = alu_res;
    assign alu_stat = {alu_ovf, alu_res[15], alu_res == 16'h0000};

    // Comparison helper; every call counts one comparison.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stores the operands and the hand-computed result for one port.
    task automatic setPort(input int p, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic [15:0] res, input logic [2:0] stat);
        pa[p]    = a;
        pb[p]    = b;
        p_op[p]  = op;
        pres[p]  = res;
        pstat[p] = stat;
    endtask

    // One cycle: drive the inputs just after the rising edge. On the falling
    // edge, check the grant and the counter, then queue the expected response
    // for the granted port.
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rrdy, input logic [1:0] exp_ready);
        @(posedge clk);
        #1;
        req_valid = valid;
        rsp_ready = rrdy;
        req_a     = {pa[1], pa[0]};
        req_b     = {pb[1], pb[0]};
        req_op    = {p_op[1], p_op[0]};
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("ops_issued", 32'(ops_issued), 32'(exp_cnt));
        if (exp_ready[0] && valid[0]) expq0.push_back({pres[0], pstat[0]});
        if (exp_ready[1] && valid[1]) expq1.push_back({pres[1], pstat[1]});
        if ((exp_ready & valid) != 2'b00 && exp_cnt != {TB_CNT_W{1'b1}})
            exp_cnt = exp_cnt + TB_CNT_W'(1);
    endtask

    // One reset cycle; anything already queued is discarded with the DUT state.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        checkOutput("req_ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq0.delete();
        expq1.delete();
        exp_cnt = '0;
    endtask

    // Scoreboard side: compares a presented response with the queue head and
    // pops the entry when it is consumed.
    task automatic monitorPort(input int p);
        logic [18:0] got;
        logic [18:0] exp;
        logic        have;
        got  = (p == 0) ? {rsp_out[15:0], rsp_stat[2:0]} : {rsp_out[31:16], rsp_stat[5:3]};
        have = (p == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
        compared++;
        if (!have) begin
            mismatched++;
            $display("[TB] FAIL rsp%0d unexpected: got %h with no response pending at %0t", p, got, $time);
        end else begin
            exp = (p == 0) ? expq0[0] : expq1[0];
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL rsp%0d {out,stat}: got %h expected %h at %0t", p, got, exp, $time);
            end
            if (rsp_ready[p]) begin
                if (p == 0) void'(expq0.pop_front());
                else        void'(expq1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid[0]) monitorPort(0);
            if (rsp_valid[1]) monitorPort(1);
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        exp_cnt   = '0;
        setPort(0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 3'b001);
        setPort(1, 16'h0000, 16'h0000, 2'b00, 16'h0000, 3'b001);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_out", rsp_out, 32'h0);
        checkOutput("rst_rsp_stat", 32'(rsp_stat), 32'h0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'h0);
        checkOutput("rst_alu_b", 32'(alu_b), 32'h0);
        checkOutput("rst_alu_control", 32'(alu_control), 32'h0);
        checkOutput("rst_ops_issued", 32'(ops_issued), 32'h0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);

        // Single ADD 0x7FFF + 1 -> 0x8000 with overflow and sign set, two-edge latency.
        $display("[TB] single ADD");
        setPort(0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b110);
        applyStimulus(2'b01, 2'b00, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00);
        checkOutput("add_alu_a", 32'(alu_a), 32'h7FFF);
        checkOutput("add_alu_b", 32'(alu_b), 32'h0001);
        checkOutput("add_alu_control", 32'(alu_control), 32'h0);
        checkOutput("add_rsp_valid_n1", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b00, 2'b01, 2'b00);
        checkOutput("add_rsp_valid_n2", 32'(rsp_valid), 32'h1);
        applyStimulus(2'b00, 2'b00, 2'b00);
        checkOutput("add_ops_issued", 32'(ops_issued), 32'h1);

        // Both ports request every cycle: grants alternate and never repeat.
        $display("[TB] alternating grants");
        doReset();
        setPort(0, 16'h0005, 16'h0005, 2'b01, 16'h0000, 3'b001);
        setPort(1, 16'h0F00, 16'h00F0, 2'b10, 16'h0FF0, 3'b000);
        t2 = '{6'b11_11_01, 6'b11_11_10, 6'b11_11_00,
               6'b11_11_01, 6'b11_11_10, 6'b11_11_00};
        for (int i = 0; i < 6; i++) applyStimulus(t2[i][5:4], t2[i][3:2], t2[i][1:0]);
        applyStimulus(2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11, 2'b00);

        // Port 0 stalls its response: no new grant to port 0 until it consumes.
        $display("[TB] response back-pressure");
        setPort(0, 16'h1234, 16'h0001, 2'b00, 16'h1235, 3'b000);
        setPort(1, 16'h0003, 16'h0005, 2'b01, 16'hFFFE, 3'b010);
        t3 = '{6'b11_10_01, 6'b11_10_10, 6'b11_10_00, 6'b11_10_00,
               6'b11_10_10, 6'b11_10_00, 6'b11_10_00, 6'b11_10_10,
               6'b11_10_00, 6'b11_11_00, 6'b11_11_01, 6'b00_11_00,
               6'b00_11_00, 6'b00_11_00};
        for (int i = 0; i < 14; i++) applyStimulus(t3[i][5:4], t3[i][3:2], t3[i][1:0]);

        // Reset while a port-1 AND is in the issue register.
        $display("[TB] reset with op in flight");
        setPort(1, 16'hFFFF, 16'h1234, 2'b11, 16'h1234, 3'b000);
        applyStimulus(2'b10, 2'b11, 2'b10);
        doReset();
        applyStimulus(2'b00, 2'b11, 2'b00);
        checkOutput("flush_alu_a", 32'(alu_a), 32'h0);
        checkOutput("flush_alu_b", 32'(alu_b), 32'h0);
        checkOutput("flush_alu_control", 32'(alu_control), 32'h0);
        checkOutput("flush_rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b00, 2'b11, 2'b00);
        checkOutput("flush_rsp_valid_later", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b11, 2'b11, 2'b01);
        applyStimulus(2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11, 2'b00);

        // Saturation of the issued-op counter under continuous traffic.
        $display("[TB] counter saturation");
        setPort(0, 16'h00FF, 16'hFF00, 2'b11, 16'h0000, 3'b001);
        setPort(1, 16'h8000, 16'h8000, 2'b00, 16'h0000, 3'b101);
        t5 = '{2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 30; i++) applyStimulus(2'b11, 2'b11, t5[i % 3]);
        checkOutput("sat_ops_issued", 32'(ops_issued), 32'hF);
        applyStimulus(2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11, 2'b00);

        // Idle: ALU inputs hold the last issued operation and nothing appears.
        $display("[TB] idle hold");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 2'b00, 2'b00);
            checkOutput("idle_alu_a", 32'(alu_a), 32'h00FF);
            checkOutput("idle_alu_b", 32'(alu_b), 32'hFF00);
            checkOutput("idle_alu_control", 32'(alu_control), 32'h3);
            checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        checkOutput("pending_rsp0", 32'(expq0.size()), 32'h0);
        checkOutput("pending_rsp1", 32'(expq1.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
